sample_xfer_seq: RTL and testbench
==================================

// Module: sample_xfer_seq
// PURPOSE
//  Parametrised sequencer that moves one event's ADC samples from the sample buffers to the readout FIFO.
//  Flow per event: wait on RDY, issue the L1A-buffer read, then step a chip/channel/sample address with one RDENA per word.
//  Chip/channel/sample counters are internal, so no external counter blocks are needed.
//  Adds downstream backpressure (HOLD), synchronous ABORT and back-to-back event chaining.
// PARAMETERS
//  NCHIP      6   chips scanned per channel, >=1
//  NCHAN      16  channels per chip, >=1
//  NSAMP      8   time samples per event, >=1
//  PRE_WAIT   4   cycles in WAIT before L1A read, >=1
//  L1A_CYC    2   cycles L1A_RD_EN held, >=1
//  CW/NW/SW derived: $clog2 of NCHIP/NCHAN/NSAMP, each minimum 1
// PORTS
//  CLK        in   1   clock
//  RST        in   1   asynchronous reset, active-high
//  RDY        in   1   event ready in sample buffers
//  JTAG_MODE  in   1   1 = JTAG owns buffers; blocks new event start
//  HOLD       in   1   readout FIFO almost-full; pause transfer
//  ABORT      in   1   synchronous abort of current event
//  L1A_RD_EN  out  1   L1A-number buffer read enable
//  RDENA      out  1   sample word read enable, one per word
//  CHIP       out  CW  chip address of word read this cycle
//  CHAN       out  NW  channel address of word read this cycle
//  SAMP       out  SW  sample address of word read this cycle
//  FIRST      out  1   with RDENA: first word of event
//  LAST       out  1   with RDENA: last word of event
//  DONE       out  1   one-cycle pulse after last word
//  BUSY       out  1   1 in any state but IDLE
// BEHAVIOUR
//  - All outputs registered; on RST all are 0, state=IDLE, counters=0. Reset mid-event discards the event.
//  - States: IDLE, WAIT, L1A_RD, XFER, DONE.
//  - IDLE: RDY && !JTAG_MODE -> WAIT. Chip/channel/sample counters and the cycle counter are cleared.
//  - WAIT: stays exactly PRE_WAIT cycles, then -> L1A_RD.
//  - L1A_RD: stays exactly L1A_CYC cycles with L1A_RD_EN=1, then -> XFER.
//  - XFER: every cycle with HOLD=0 at the preceding edge:
//    - RDENA=1, with CHIP/CHAN/SAMP = current counters.
//    - Counters then advance. CHIP is fastest and wraps NCHIP-1->0 with CHAN++.
//    - CHAN wraps NCHAN-1->0 with SAMP++.
//  - HOLD latency: HOLD seen at edge k gives RDENA=0 in cycle k+1, with counters and addresses frozen.
//    Downstream must assert HOLD with >=1 word of margin.
//  - Word count: exactly NCHIP*NCHAN*NSAMP RDENA pulses per event, with no repeated or skipped address.
//  - FIRST accompanies word (0,0,0); LAST accompanies word (NCHIP-1,NCHAN-1,NSAMP-1).
//  - After the last word -> DONE: DONE=1 for one cycle.
//    Next: RDY && !JTAG_MODE -> WAIT (back-to-back, counters cleared); else -> IDLE.
//  - JTAG_MODE is checked only at event start. Asserting it mid-event does not stop the event.
//  - HOLD high in IDLE/WAIT/L1A_RD has no effect.
//  - ABORT=1 in any state -> IDLE next cycle, overriding HOLD and all transitions:
//    - RDENA and L1A_RD_EN are 0 that cycle; counters are cleared; DONE is not pulsed.
//  - NCHIP=1 or NCHAN=1: the corresponding counter stays 0 and wraps every word.
// TESTING
//  - Defaults, RDY pulse, HOLD=0 -> WAIT 4, L1A_RD_EN 2 cycles, 768 contiguous RDENA in order, FIRST/LAST, 1 DONE.
//  - HOLD high for 5 cycles after word 100 -> exactly 5 RDENA gaps, word 101 follows the gap, 768 words total.
//  - RDY held high -> DONE directly followed by WAIT; second event also gives 768 words.
//  - JTAG_MODE=1 with RDY=1 -> stays IDLE, BUSY=0; toggling JTAG_MODE mid-event -> event completes.
//  - ABORT at word 300, then RST mid-XFER -> IDLE next cycle, all outputs 0, no DONE; next event restarts at (0,0,0).
//  - NCHIP=5,NCHAN=1,NSAMP=3 -> 15 words, CHAN always 0, LAST on (4,0,2).

Source files
------------

// File: rtl/sample_xfer_seq.sv
`default_nettype none
// ============================================================================
//  Module   : sample_xfer_seq
//  Purpose  : Moves one event's ADC samples from the sample buffers to the
//             readout FIFO. When RDY is seen, it waits, reads the L1A-number
//             buffer, then walks a chip/channel/sample address with one
//             RDENA per word. It supports downstream backpressure (HOLD),
//             a synchronous ABORT, and back-to-back event chaining.
//  Ports    : CLK, RST (async, active-high)
//             RDY, JTAG_MODE, HOLD, ABORT                  - control inputs
//             L1A_RD_EN                                    - L1A buffer read
//             RDENA, CHIP, CHAN, SAMP, FIRST, LAST         - word read strobe
//             DONE (one-cycle pulse), BUSY (not IDLE)      - status
//  Revision : 1.0 - initial release
// ============================================================================
module sample_xfer_seq #(
    parameter int NCHIP    = 6,
    parameter int NCHAN    = 16,
    parameter int NSAMP    = 8,
    parameter int PRE_WAIT = 4,
    parameter int L1A_CYC  = 2,
    localparam int CW = (NCHIP > 1) ? $clog2(NCHIP) : 1,
    localparam int NW = (NCHAN > 1) ? $clog2(NCHAN) : 1,
    localparam int SW = (NSAMP > 1) ? $clog2(NSAMP) : 1
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          RDY,
    input  logic          JTAG_MODE,
    input  logic          HOLD,
    input  logic          ABORT,
    output logic          L1A_RD_EN,
    output logic          RDENA,
    output logic [CW-1:0] CHIP,
    output logic [NW-1:0] CHAN,
    output logic [SW-1:0] SAMP,
    output logic          FIRST,
    output logic          LAST,
    output logic          DONE,
    output logic          BUSY
);

    localparam int CYCMAX = (PRE_WAIT > L1A_CYC) ? PRE_WAIT : L1A_CYC;
    localparam int CYW    = (CYCMAX > 1) ? $clog2(CYCMAX) : 1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_L1A  = 3'd2,
        ST_XFER = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    state_t          r_state;
    logic [CYW-1:0]  r_cyc;
    logic [CW-1:0]   r_chip;
    logic [NW-1:0]   r_chan;
    logic [SW-1:0]   r_samp;

    logic            w_start;
    logic            w_slot;
    logic            w_issue;
    logic            w_chip_max;
    logic            w_chan_max;
    logic            w_samp_max;
    logic [CW-1:0]   w_chip_nxt;
    logic [NW-1:0]   w_chan_nxt;
    logic [SW-1:0]   w_samp_nxt;

    assign w_start    = RDY && !JTAG_MODE;
    assign w_chip_max = (r_chip == CW'(NCHIP - 1));
    assign w_chan_max = (r_chan == NW'(NCHAN - 1));
    assign w_samp_max = (r_samp == SW'(NSAMP - 1));

    // Chip is the fastest index; channel advances on chip wrap, sample on
    // channel wrap. Degenerate dimensions (size 1) simply wrap every word.
    always_comb begin
        w_chip_nxt = w_chip_max ? '0 : r_chip + CW'(1);
        w_chan_nxt = r_chan;
        w_samp_nxt = r_samp;
        if (w_chip_max) begin
            w_chan_nxt = w_chan_max ? '0 : r_chan + NW'(1);
            if (w_chan_max) begin
                w_samp_nxt = w_samp_max ? '0 : r_samp + SW'(1);
            end
        end
    end

    // A word may be issued on the edge that leaves L1A_RD and on every XFER
    // edge until the last word is on the bus (LAST high means the word
    // currently presented is the final one, so the next edge goes to DONE).
    always_comb begin
        w_slot = 1'b0;
        case (r_state)
            ST_L1A:  w_slot = (r_cyc == CYW'(L1A_CYC - 1));
            ST_XFER: w_slot = !LAST;
            default: w_slot = 1'b0;
        endcase
    end

    assign w_issue = w_slot && !HOLD && !ABORT;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state   <= ST_IDLE;
            r_cyc     <= '0;
            r_chip    <= '0;
            r_chan    <= '0;
            r_samp    <= '0;
            L1A_RD_EN <= 1'b0;
            RDENA     <= 1'b0;
            CHIP      <= '0;
            CHAN      <= '0;
            SAMP      <= '0;
            FIRST     <= 1'b0;
            LAST      <= 1'b0;
            DONE      <= 1'b0;
            BUSY      <= 1'b0;
        end else begin
            RDENA     <= 1'b0;
            L1A_RD_EN <= 1'b0;
            DONE      <= 1'b0;
            FIRST     <= 1'b0;
            LAST      <= 1'b0;

            if (ABORT) begin
                r_state <= ST_IDLE;
                r_cyc   <= '0;
                r_chip  <= '0;
                r_chan  <= '0;
                r_samp  <= '0;
                CHIP    <= '0;
                CHAN    <= '0;
                SAMP    <= '0;
                BUSY    <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_cyc  <= '0;
                        r_chip <= '0;
                        r_chan <= '0;
                        r_samp <= '0;
                        if (w_start) begin
                            r_state <= ST_WAIT;
                            BUSY    <= 1'b1;
                        end
                    end
                    ST_WAIT: begin
                        if (r_cyc == CYW'(PRE_WAIT - 1)) begin
                            r_state   <= ST_L1A;
                            r_cyc     <= '0;
                            L1A_RD_EN <= 1'b1;
                        end else begin
                            r_cyc <= r_cyc + CYW'(1);
                        end
                    end
                    ST_L1A: begin
                        if (r_cyc == CYW'(L1A_CYC - 1)) begin
                            r_state <= ST_XFER;
                            r_cyc   <= '0;
                        end else begin
                            r_cyc     <= r_cyc + CYW'(1);
                            L1A_RD_EN <= 1'b1;
                        end
                    end
                    ST_XFER: begin
                        if (LAST) begin
                            r_state <= ST_DONE;
                            DONE    <= 1'b1;
                        end
                    end
                    ST_DONE: begin
                        r_cyc  <= '0;
                        r_chip <= '0;
                        r_chan <= '0;
                        r_samp <= '0;
                        if (w_start) begin
                            r_state <= ST_WAIT;
                        end else begin
                            r_state <= ST_IDLE;
                            BUSY    <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        BUSY    <= 1'b0;
                    end
                endcase

                if (w_issue) begin
                    RDENA  <= 1'b1;
                    CHIP   <= r_chip;
                    CHAN   <= r_chan;
                    SAMP   <= r_samp;
                    FIRST  <= (r_chip == '0) && (r_chan == '0) && (r_samp == '0);
                    LAST   <= w_chip_max && w_chan_max && w_samp_max;
                    r_chip <= w_chip_nxt;
                    r_chan <= w_chan_nxt;
                    r_samp <= w_samp_nxt;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sample_xfer_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sample_xfer_seq
//  Purpose  : Self-checking bench for sample_xfer_seq. Two instances are
//             used: the default geometry (6x16x8) and a small 5x1x3 one.
//             Expected words are queued when an event is launched; monitors
//             pop and compare every RDENA word.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sample_xfer_seq;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;

    logic       RDY = 1'b0, JTAG_MODE = 1'b0, HOLD = 1'b0, ABORT = 1'b0;
    logic       L1A_RD_EN, RDENA, FIRST, LAST, DONE, BUSY;
    logic [2:0] CHIP;
    logic [3:0] CHAN;
    logic [2:0] SAMP;

    logic       RDY_2 = 1'b0, JTAG_MODE_2 = 1'b0, HOLD_2 = 1'b0, ABORT_2 = 1'b0;
    logic       L1A_RD_EN_2, RDENA_2, FIRST_2, LAST_2, DONE_2, BUSY_2;
    logic [2:0] CHIP_2;
    logic [0:0] CHAN_2;
    logic [1:0] SAMP_2;

    int n_checks = 0;
    int n_errors = 0;

    logic [11:0] exp_q[$];
    logic [7:0]  exp_q2[$];
    logic [11:0] e1;
    logic [7:0]  e2;

    always #5 CLK = ~CLK;

    sample_xfer_seq dut (
        .CLK(CLK), .RST(RST), .RDY(RDY), .JTAG_MODE(JTAG_MODE), .HOLD(HOLD),
        .ABORT(ABORT), .L1A_RD_EN(L1A_RD_EN), .RDENA(RDENA), .CHIP(CHIP),
        .CHAN(CHAN), .SAMP(SAMP), .FIRST(FIRST), .LAST(LAST), .DONE(DONE),
        .BUSY(BUSY)
    );

    sample_xfer_seq #(.NCHIP(5), .NCHAN(1), .NSAMP(3)) dut2 (
        .CLK(CLK), .RST(RST), .RDY(RDY_2), .JTAG_MODE(JTAG_MODE_2), .HOLD(HOLD_2),
        .ABORT(ABORT_2), .L1A_RD_EN(L1A_RD_EN_2), .RDENA(RDENA_2), .CHIP(CHIP_2),
        .CHAN(CHAN_2), .SAMP(SAMP_2), .FIRST(FIRST_2), .LAST(LAST_2), .DONE(DONE_2),
        .BUSY(BUSY_2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected word order for the default geometry: chip fastest, then channel, then sample.
    task automatic push_event1();
        int idx = 0;
        for (int s = 0; s < 8; s++)
            for (int ch = 0; ch < 16; ch++)
                for (int c = 0; c < 6; c++) begin
                    exp_q.push_back({3'(c), 4'(ch), 3'(s), (idx == 0), (idx == 767)});
                    idx++;
                end
    endtask

    task automatic push_event2();
        int idx = 0;
        for (int s = 0; s < 3; s++)
            for (int c = 0; c < 5; c++) begin
                exp_q2.push_back({3'(c), 1'b0, 2'(s), (idx == 0), (idx == 14)});
                idx++;
            end
    endtask

    // Scoreboard monitors
    always @(negedge CLK) begin
        if (RDENA) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL sb_extra_word: got %0h expected none", {CHIP, CHAN, SAMP, FIRST, LAST});
            end else begin
                e1 = exp_q.pop_front();
                check("sb_word", {20'd0, CHIP, CHAN, SAMP, FIRST, LAST}, {20'd0, e1});
            end
        end
    end

    always @(negedge CLK) begin
        if (RDENA_2) begin
            if (exp_q2.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL sb2_extra_word: got %0h expected none", {CHIP_2, CHAN_2, SAMP_2, FIRST_2, LAST_2});
            end else begin
                e2 = exp_q2.pop_front();
                check("sb2_word", {24'd0, CHIP_2, CHAN_2, SAMP_2, FIRST_2, LAST_2}, {24'd0, e2});
            end
        end
    end

    // Runs one event on the default instance, measuring phase lengths and
    // optionally injecting HOLD, ABORT, RST or JTAG_MODE toggles at given words.
    task automatic run_event(input int hold_at, input int abort_at, input int rst_at,
                             input bit keep_rdy, input bit jtag_tog,
                             output int waitc, output int l1ac, output int words,
                             output int gaps, output bit first_busy);
        int hcnt    = 0;
        bit started = 1'b0;
        bit ended   = 1'b0;
        bit stop    = 1'b0;
        waitc = 0; l1ac = 0; words = 0; gaps = 0; first_busy = 1'b0;
        for (int cyc = 0; cyc < 2000 && !stop; cyc++) begin
            @(negedge CLK);
            if (cyc == 0) first_busy = BUSY;
            if (!keep_rdy) RDY = 1'b0;
            if (hcnt > 0) begin
                hcnt--;
                if (hcnt == 0) HOLD = 1'b0;
            end
            if (BUSY && !L1A_RD_EN && !started && l1ac == 0) waitc++;
            if (L1A_RD_EN) l1ac++;
            if (RDENA) begin
                started = 1'b1;
                if (words == hold_at) begin HOLD = 1'b1; hcnt = 5; end
                if (words == abort_at) begin ABORT = 1'b1; stop = 1'b1; end
                if (words == rst_at) begin #1 RST = 1'b1; stop = 1'b1; end
                if (jtag_tog && (words % 97) == 0) JTAG_MODE = !JTAG_MODE;
                if (LAST) ended = 1'b1;
                words++;
            end else if (started && !ended) begin
                gaps++;
            end
            if (DONE) stop = 1'b1;
        end
        check("event_end", {31'd0, stop}, 32'd1);
    endtask

    task automatic check_event(input string tag, input int waitc, input int l1ac,
                               input int words, input int gaps, input int exp_gaps);
        check({tag, "_wait"},  waitc, 4);
        check({tag, "_l1a"},   l1ac,  2);
        check({tag, "_words"}, words, 768);
        check({tag, "_gaps"},  gaps,  exp_gaps);
    endtask

    initial begin
        int  wc, lc, wd, gp, n2, d2;
        bit  fb;
        bit  any_busy;

        // Reset state
        repeat (2) @(negedge CLK);
        check("reset_outputs", {L1A_RD_EN, RDENA, CHIP, CHAN, SAMP, FIRST, LAST, DONE, BUSY}, 0);
        RST = 1'b0;
        @(negedge CLK);
        check("post_reset_idle", {31'd0, BUSY}, 0);

        // Basic event: single RDY pulse, no HOLD
        push_event1();
        RDY = 1'b1;
        run_event(-1, -1, -1, 1'b0, 1'b0, wc, lc, wd, gp, fb);
        check_event("ev1", wc, lc, wd, gp, 0);
        @(negedge CLK);
        check("ev1_done_one_cycle", {DONE, BUSY}, 0);

        // HOLD for 5 cycles after word 100
        push_event1();
        RDY = 1'b1;
        run_event(100, -1, -1, 1'b0, 1'b0, wc, lc, wd, gp, fb);
        check_event("hold", wc, lc, wd, gp, 5);
        @(negedge CLK);

        // Back-to-back: RDY held through DONE
        push_event1();
        push_event1();
        RDY = 1'b1;
        run_event(-1, -1, -1, 1'b1, 1'b0, wc, lc, wd, gp, fb);
        check_event("b2b1", wc, lc, wd, gp, 0);
        run_event(-1, -1, -1, 1'b0, 1'b0, wc, lc, wd, gp, fb);
        check("b2b_wait_after_done", {31'd0, fb}, 1);
        check_event("b2b2", wc, lc, wd, gp, 0);
        @(negedge CLK);

        // JTAG_MODE blocks event start
        JTAG_MODE = 1'b1;
        RDY = 1'b1;
        any_busy = 1'b0;
        repeat (10) begin
            @(negedge CLK);
            any_busy = any_busy | BUSY | L1A_RD_EN | RDENA;
        end
        check("jtag_blocks_start", {31'd0, any_busy}, 0);

        // Releasing JTAG_MODE starts the event; toggling mid-event does not stop it
        push_event1();
        JTAG_MODE = 1'b0;
        run_event(-1, -1, -1, 1'b0, 1'b1, wc, lc, wd, gp, fb);
        check_event("jtag_tog", wc, lc, wd, gp, 0);
        JTAG_MODE = 1'b0;
        @(negedge CLK);

        // ABORT at word 300
        push_event1();
        RDY = 1'b1;
        run_event(-1, 300, -1, 1'b0, 1'b0, wc, lc, wd, gp, fb);
        check("abort_words", wd, 301);
        @(negedge CLK);
        ABORT = 1'b0;
        check("abort_outputs", {L1A_RD_EN, RDENA, CHIP, CHAN, SAMP, FIRST, LAST, DONE, BUSY}, 0);
        exp_q.delete();
        repeat (3) @(negedge CLK);
        check("abort_no_done", {DONE, BUSY, RDENA}, 0);

        // Asynchronous RST mid-XFER
        push_event1();
        RDY = 1'b1;
        run_event(-1, -1, 50, 1'b0, 1'b0, wc, lc, wd, gp, fb);
        #1;
        check("rst_outputs", {L1A_RD_EN, RDENA, CHIP, CHAN, SAMP, FIRST, LAST, DONE, BUSY}, 0);
        @(negedge CLK);
        RST = 1'b0;
        exp_q.delete();
        @(negedge CLK);

        // Next event restarts at (0,0,0)
        push_event1();
        RDY = 1'b1;
        run_event(-1, -1, -1, 1'b0, 1'b0, wc, lc, wd, gp, fb);
        check_event("restart", wc, lc, wd, gp, 0);
        @(negedge CLK);

        // Small geometry: 5 chips, 1 channel, 3 samples
        push_event2();
        RDY_2 = 1'b1;
        n2 = 0;
        d2 = 0;
        for (int cyc = 0; cyc < 200 && d2 == 0; cyc++) begin
            @(negedge CLK);
            RDY_2 = 1'b0;
            if (RDENA_2) n2++;
            if (DONE_2) d2++;
        end
        check("small_words", n2, 15);
        check("small_done", d2, 1);
        @(negedge CLK);

        check("sb_queue_empty", exp_q.size(), 0);
        check("sb2_queue_empty", exp_q2.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
